// File: rtl/bram_pkg.sv
// Shared types, constants and parameter checks for the byte-strobed SDP RAM.
package bram_pkg;

    typedef enum logic {CLEAR, RUN} bram_state_t;

    localparam int BYTE_W = 8;

    function automatic int lanes(input int data_w);
        return data_w / BYTE_W;
    endfunction

    function automatic bit params_ok(input int rd_lat, input int data_w);
        return ((rd_lat == 1) || (rd_lat == 2)) && ((data_w % BYTE_W) == 0);
    endfunction

endpackage

// File: rtl/bram_sdp_core.sv
// Bare byte-strobed storage array: one write port, one registered read port, no reset.
// Reads are read-first: a same-address write in the same cycle is not visible.
module bram_sdp_core
    import bram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [ADDR_W-1:0]         waddr_i,
    input  logic [DATA_W-1:0]         wdata_i,
    input  logic [lanes(DATA_W)-1:0]  wstrb_i,
    input  logic                      re_i,
    input  logic [ADDR_W-1:0]         raddr_i,
    output logic [DATA_W-1:0]         rdata_o
);

    localparam int NL = lanes(DATA_W);

    (* ram_style = "block" *) logic [DATA_W-1:0] ram [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < NL; i++) begin
                if (wstrb_i[i]) ram[waddr_i][i*BYTE_W +: BYTE_W] <= wdata_i[i*BYTE_W +: BYTE_W];
            end
        end
        if (re_i) rdata_q <= ram[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_sdp_be.sv
// Simple-dual-port byte-strobed RAM with zero-clear sequencer and 1/2-cycle read latency.
// Define BRAM_SDP_BYPASS_EN to make same-address read/write collisions return write-first data.
module bram_sdp_be
    import bram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    output logic                      init_busy_o,
    input  logic                      we_i,
    input  logic [ADDR_W-1:0]         waddr_i,
    input  logic [DATA_W-1:0]         wdata_i,
    input  logic [lanes(DATA_W)-1:0]  wstrb_i,
    input  logic                      re_i,
    input  logic [ADDR_W-1:0]         raddr_i,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      rvalid_o
);

    localparam int NL = lanes(DATA_W);

    if (!params_ok(RD_LAT, DATA_W)) begin : g_bad_cfg
        $error("bram_sdp_be: RD_LAT must be 1 or 2 and DATA_W a multiple of 8");
    end

    bram_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              run;
    logic              req_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign run         = (state_q == RUN);
    assign req_ok      = run & ~rst_i;
    assign init_busy_o = ~run;

    // While clearing, the write port is owned by the sequencer.
    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [NL-1:0]     mem_wstrb;
    logic [DATA_W-1:0] mem_rdata;

    assign mem_we    = run ? (req_ok & we_i) : ~rst_i;
    assign mem_waddr = run ? waddr_i : cnt_q;
    assign mem_wdata = run ? wdata_i : '0;
    assign mem_wstrb = run ? wstrb_i : '1;
    assign mem_re    = req_ok & re_i;

    bram_sdp_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .wstrb_i (mem_wstrb),
        .re_i    (mem_re),
        .raddr_i (raddr_i),
        .rdata_o (mem_rdata)
    );

    logic [RD_LAT-1:0] vld_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) vld_q <= '0;
        else       vld_q <= RD_LAT'({vld_q, mem_re});
    end

    logic [DATA_W-1:0] stg1_data;

`ifdef BRAM_SDP_BYPASS_EN
    logic [NL-1:0]     fwd_mask_q;
    logic [DATA_W-1:0] fwd_data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)       fwd_mask_q <= '0;
        else if (mem_re) fwd_mask_q <= (we_i && (waddr_i == raddr_i)) ? wstrb_i : '0;
    end

    always_ff @(posedge clk_i) begin
        if (mem_re) fwd_data_q <= wdata_i;
    end

    always_comb begin
        stg1_data = mem_rdata;
        for (int i = 0; i < NL; i++) begin
            if (fwd_mask_q[i]) stg1_data[i*BYTE_W +: BYTE_W] = fwd_data_q[i*BYTE_W +: BYTE_W];
        end
    end
`else
    assign stg1_data = mem_rdata;
`endif

    // The array output has no reset, so rdata is presented through a resettable hold/stage register.
    logic [DATA_W-1:0] out_q;

    if (RD_LAT == 1) begin : g_lat1
        always_ff @(posedge clk_i) begin
            if (rst_i)         out_q <= '0;
            else if (vld_q[0]) out_q <= stg1_data;
        end
        assign rdata_o = vld_q[0] ? stg1_data : out_q;
    end else begin : g_lat2
        always_ff @(posedge clk_i) begin
            if (rst_i)         out_q <= '0;
            else if (vld_q[0]) out_q <= stg1_data;
        end
        assign rdata_o = out_q;
    end

    assign rvalid_o = vld_q[RD_LAT-1];

endmodule

// File: tb/tb_bram_sdp_be.sv
// Directed bench driving an RD_LAT=1 and an RD_LAT=2 instance with identical stimulus.
module tb_bram_sdp_be;

    logic        clk = 1'b0;
    logic        rst;
    logic        we, re;
    logic [9:0]  waddr, raddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        busy1, busy2, rv1, rv2;
    logic [31:0] rd1, rd2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bram_sdp_be #(.DATA_W(32), .ADDR_W(10), .RD_LAT(1)) u_lat1 (
        .clk_i(clk), .rst_i(rst), .init_busy_o(busy1),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wstrb_i(wstrb),
        .re_i(re), .raddr_i(raddr), .rdata_o(rd1), .rvalid_o(rv1)
    );

    bram_sdp_be #(.DATA_W(32), .ADDR_W(10), .RD_LAT(2)) u_lat2 (
        .clk_i(clk), .rst_i(rst), .init_busy_o(busy2),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wstrb_i(wstrb),
        .re_i(re), .raddr_i(raddr), .rdata_o(rd2), .rvalid_o(rv2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d; wstrb = s;
        @(posedge clk); #1;
        we = 1'b0; wstrb = 4'h0;
    endtask

    task automatic read_chk(input logic [9:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        re = 1'b1; raddr = a;
        @(posedge clk); #1;
        re = 1'b0;
        chk({tag, "_rv1"}, {31'd0, rv1}, 32'd1);
        chk({tag, "_rd1"}, rd1, exp);
        chk({tag, "_rv2_early"}, {31'd0, rv2}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_rv2"}, {31'd0, rv2}, 32'd1);
        chk({tag, "_rd2"}, rd2, exp);
        chk({tag, "_rv1_off"}, {31'd0, rv1}, 32'd0);
        chk({tag, "_rd1_hold"}, rd1, exp);
    endtask

    // Releases reset and counts cycles until init_busy falls; optionally pokes requests mid-clear.
    task automatic wait_clear(input bit poke, input string tag);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        while (n < 2000) begin
            @(posedge clk); #1;
            n++;
            we = 1'b0; re = 1'b0;
            if (rv1 || rv2) seen = 1'b1;
            if (!busy1) break;
            if (poke && n == 500) begin
                we = 1'b1; waddr = 10'd10; wdata = 32'h12345678; wstrb = 4'hF;
                re = 1'b1; raddr = 10'd10;
            end
        end
        chk({tag, "_busy_cycles"}, n, 1024);
        chk({tag, "_busy2_low"}, {31'd0, busy2}, 32'd0);
        chk({tag, "_no_rvalid"}, {31'd0, seen}, 32'd0);
    endtask

    logic [31:0] exp_coll;

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0;
        waddr = '0; raddr = '0; wdata = '0; wstrb = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy1", {31'd0, busy1}, 32'd1);
        chk("rst_busy2", {31'd0, busy2}, 32'd1);
        chk("rst_rv1", {31'd0, rv1}, 32'd0);
        chk("rst_rv2", {31'd0, rv2}, 32'd0);
        chk("rst_rd1", rd1, 32'h0);
        chk("rst_rd2", rd2, 32'h0);

        wait_clear(1'b0, "clear1");
        read_chk(10'd0,    32'h0, "clr_a0");
        read_chk(10'd511,  32'h0, "clr_a511");
        read_chk(10'd1023, 32'h0, "clr_a1023");

        wr(10'd5, 32'hAABBCCDD, 4'b1111);
        wr(10'd5, 32'h11223344, 4'b0101);
        read_chk(10'd5, 32'hAA22CC44, "strb_merge");
        wr(10'd5, 32'hFFFFFFFF, 4'b0000);
        read_chk(10'd5, 32'hAA22CC44, "strb_zero_noop");

        for (int i = 1; i <= 4; i++) wr(10'(i), 32'h10 + 32'(i - 1), 4'hF);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            re = (k <= 4); raddr = 10'(k);
            @(posedge clk); #1;
            re = 1'b0;
            chk($sformatf("b2b_rv1_%0d", k), {31'd0, rv1}, (k <= 4) ? 32'd1 : 32'd0);
            if (k <= 4) chk($sformatf("b2b_rd1_%0d", k), rd1, 32'h10 + 32'(k - 1));
            chk($sformatf("b2b_rv2_%0d", k), {31'd0, rv2}, (k >= 2 && k <= 5) ? 32'd1 : 32'd0);
            if (k >= 2 && k <= 5) chk($sformatf("b2b_rd2_%0d", k), rd2, 32'h10 + 32'(k - 2));
        end

`ifdef BRAM_SDP_BYPASS_EN
        exp_coll = 32'hFFFF0000;
`else
        exp_coll = 32'h00000000;
`endif
        @(negedge clk);
        we = 1'b1; waddr = 10'd7; wdata = 32'hFFFF0000; wstrb = 4'hF;
        re = 1'b1; raddr = 10'd7;
        @(posedge clk); #1;
        we = 1'b0; re = 1'b0; wstrb = 4'h0;
        chk("coll_rv1", {31'd0, rv1}, 32'd1);
        chk("coll_rd1", rd1, exp_coll);
        @(posedge clk); #1;
        chk("coll_rv2", {31'd0, rv2}, 32'd1);
        chk("coll_rd2", rd2, exp_coll);
        read_chk(10'd7, 32'hFFFF0000, "coll_after");

        wr(10'd3, 32'hDEADBEEF, 4'hF);
        read_chk(10'd3, 32'hDEADBEEF, "pre_rst_a3");
        @(negedge clk);
        re = 1'b1; raddr = 10'd3;
        @(posedge clk); #1;
        re = 1'b0;
        chk("midrst_rv2_e0", {31'd0, rv2}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_rv1", {31'd0, rv1}, 32'd0);
        chk("midrst_rv2", {31'd0, rv2}, 32'd0);
        chk("midrst_busy1", {31'd0, busy1}, 32'd1);
        chk("midrst_rd1", rd1, 32'h0);
        chk("midrst_rd2", rd2, 32'h0);
        @(posedge clk); #1;
        chk("midrst_rv2_late", {31'd0, rv2}, 32'd0);

        wait_clear(1'b1, "clear2");
        read_chk(10'd3,  32'h0, "reclr_a3");
        read_chk(10'd10, 32'h0, "reclr_a10");
        read_chk(10'd5,  32'h0, "reclr_a5");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bram_sdp_be.md
Name: bram_sdp_be

Overview:
- Parametrised simple-dual-port block RAM: one write port with byte strobes and one independent read port, both on the same clock.
- Configurable read latency of 1 or 2 cycles, with a read-valid output.
- Built-in zero-clear sequencer runs after every reset, so memory contents are defined.
- General-purpose storage for the core: instruction/data memory and register-file backing, replacing the fixed 32x1024 single-port RAM.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W words.
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2 (2 adds an output register).

Ports:
- clk  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- init_busy  out  1  high while the clear sequence runs; all port requests are ignored while it is high.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte-lane enables; bit i controls wdata[8i+7:8i].
- re  in  1  read enable.
- raddr  in  ADDR_W  read address.
- rdata  out  DATA_W  read data; valid when rvalid is high, otherwise holds its last value.
- rvalid  out  1  one-cycle pulse, RD_LAT cycles after an accepted read.

Behaviour:
- Reset (rst=1 sampled at an edge):
  - FSM goes to CLEAR and the clear counter goes to 0.
  - init_busy=1, rvalid=0, rdata=0.
  - Any read in the latency pipeline is discarded.
  - rst asserted mid-CLEAR restarts the clear at address 0.
- FSM states:
  - CLEAR: each cycle with rst=0, write all-zero to ram[cnt] with all lanes enabled, then cnt++. The cycle that writes address DEPTH-1 transitions to RUN. init_busy deasserts on the first RUN cycle. CLEAR therefore lasts exactly DEPTH cycles after rst falls.
  - RUN: normal operation; the FSM stays here until rst.
- In CLEAR, we and re are ignored: no write happens and no rvalid is produced. Requesters must wait for init_busy=0.
- Write (RUN, we=1):
  - At the edge, for each lane with wstrb[i]=1, ram[waddr] lane i <= wdata lane i.
  - Lanes with wstrb[i]=0 keep their old value.
  - we=1 with wstrb=0 is a legal no-op.
- Read (RUN, re=1):
  - RD_LAT=1: rdata and rvalid update at the edge after the request.
  - RD_LAT=2: a second register stage is added, so rvalid goes high two edges after the request.
  - The pipeline is fully pipelined: back-to-back reads give back-to-back rvalid.
  - No backpressure.
- Read and write in the same cycle, different addresses: fully independent.
- Read and write in the same cycle, same address: read-first, i.e. rdata returns the pre-write contents (unless the optional feature is enabled).
- Address wrap-around is impossible, because DEPTH = 2**ADDR_W.
- Storage array carries no reset; only the control/pipeline registers and rdata are reset. Contents come from the CLEAR sequence.

Optional Feature:
- Macro: BRAM_SDP_BYPASS_EN.
- Defined: a same-cycle read/write hit on the same address returns write-first data. Lanes with wstrb=1 come from wdata; the other lanes come from ram. This is done by forwarding registered alongside the read. Latency is unchanged.
- Undefined: read-first as above, and no forwarding logic is synthesised. The storage keeps ram_style "block".

Decomposition:
- Package bram_pkg:
  - typedef enum logic {CLEAR, RUN} bram_state_t.
  - localparam BYTE_W = 8.
  - function lanes(DATA_W) returning DATA_W/8.
  - Elaboration check that RD_LAT is in {1,2} and DATA_W % 8 == 0.
- One sub-module, bram_sdp_core:
  - The bare byte-strobed array: write port plus registered read, no reset.
  - Kept separate so it infers cleanly as BRAM.
  - The top level holds the FSM, the clear mux on the write port, the latency pipeline and the bypass.

Test Plan:
- Reset then idle: rst high 2 cycles, then low. init_busy must stay 1 for exactly 1024 cycles, then 0. Reading addresses 0, 511 and 1023 returns 0x00000000 with rvalid RD_LAT cycles later.
- Strobe merge: write addr 5 = 0xAABBCCDD with wstrb=1111, then write 0x11223344 with wstrb=0101. Reading addr 5 returns 0xAA22CC44.
- Back-to-back reads, RD_LAT=2: write addrs 1..4 = 0x10..0x13. Assert re for 4 consecutive cycles. rvalid is high for 4 consecutive cycles starting 2 edges after the first re, with rdata 0x10, 0x11, 0x12, 0x13.
- Same-address collision: addr 7 holds 0x0; in one cycle write 0xFFFF0000 (wstrb=1111) and read addr 7. Without the macro, rdata=0x00000000. With BRAM_SDP_BYPASS_EN, rdata=0xFFFF0000. A following read returns 0xFFFF0000 in both builds.
- Reset mid-operation: write 0xDEADBEEF to addr 3, issue a read, assert rst on the cycle after. No rvalid may appear. After the re-clear (1024 cycles), addr 3 reads 0.
- Requests during CLEAR: pulse we to addr 10 with 0x12345678 and pulse re while init_busy=1. No rvalid appears, and after init_busy falls, addr 10 reads 0.
